mnist_canvas_renderer: RTL and testbench

- Pixel-generation stage directly downstream of vga_display. Consumes its x, y, video_on, hsync and vsync; produces the registered 8-bit RGB332 colour and pipeline-aligned sync outputs for the board VGA connector.
- Holds a 28x28 8-bit grayscale image buffer: the MNIST digit drawn by the user and fed to the network. Draws it as a SCALE-magnified square with a 1-pixel border on a black background.
- Buffer loaded through a simple write port, with a one-shot hardware clear sweep.

---
 rtl/mnist_pkg.sv | 32 +++
 rtl/mnist_img_ram.sv | 41 ++++
 rtl/mnist_canvas_renderer.sv | 200 ++++++++++++++++++++
 tb/tb_mnist_canvas_renderer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// mnist_pkg
// Shared constants and helpers for the MNIST digit image path: image
// geometry, buffer address/pixel widths, RGB332 field widths, the clear-sweep
// FSM state type and the grayscale-to-RGB332 conversion used by every block
// that puts image cells on the screen.
package mnist_pkg;

  localparam int IMG_DIM   = 28;
  localparam int IMG_CELLS = IMG_DIM * IMG_DIM;  // 784

  localparam int ADDR_W = 10;
  localparam int PIX_W  = 8;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_CELLS - 1);  // 783

  // RGB332: {red[2:0], green[2:0], blue[1:0]}
  localparam int R_W = 3;
  localparam int G_W = 3;
  localparam int B_W = 2;

  typedef enum logic [0:0] {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_t;

  // A gray level maps to an RGB332 gray by replicating its top bits into each
  // colour field, so 0 stays black and 255 stays white.
  function automatic logic [R_W+G_W+B_W-1:0] gray_to_rgb332(input logic [PIX_W-1:0] g);
    return {g[PIX_W-1 -: R_W], g[PIX_W-1 -: G_W], g[PIX_W-1 -: B_W]};
  endfunction

endpackage

// File: rtl/mnist_img_ram.sv
// mnist_img_ram
// 784x8 simple dual-port synchronous RAM holding one 28x28 grayscale image.
// Written as a plain registered-read array so it infers block RAM.
//
// Ports:
//   clk    in   clock
//   we     in   write enable; writes to addresses above 783 are ignored
//   waddr  in   write cell index
//   wdata  in   write data
//   raddr  in   read cell index, sampled every clk
//   rdata  out  registered read data; out-of-range reads return 0
//
// A read and a write to the same address on the same clk return the old
// contents; the new value appears on the following read.
module mnist_img_ram
  import mnist_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [0:IMG_CELLS-1];

  // Read and write share one block so the non-blocking write lands after the
  // read has sampled the old value.
  always_ff @(posedge clk) begin
    if (we && (waddr <= LAST_ADDR)) begin
      mem[waddr] <= wdata;
    end
    if (raddr <= LAST_ADDR) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/mnist_canvas_renderer.sv
// mnist_canvas_renderer
// Pixel stage behind vga_display. Draws the 28x28 digit buffer as a
// magnified square (8x8 screen pixels per cell by default) with a 1-pixel
// border on a black background, and delays the syncs to stay aligned with
// the registered colour. Latency from x/y/syncs to rgb/hsync/vsync is 2 clk.
//
// Ports:
//   clk       in   100 MHz system clock
//   reset     in   synchronous, active-high reset
//   x, y      in   current pixel column/row from vga_display
//   video_on  in   visible-area flag
//   hsync_in  in   horizontal sync from vga_display
//   vsync_in  in   vertical sync from vga_display
//   wr_en     in   buffer write strobe
//   wr_addr   in   cell index row*28+col (0..783)
//   wr_data   in   grayscale value
//   clear     in   one-cycle pulse starting a zeroing sweep of the buffer
//   busy      out  high while the clear sweep runs
//   hsync     out  hsync_in delayed 2 clk
//   vsync     out  vsync_in delayed 2 clk
//   rgb       out  RGB332 pixel colour
//
// Write handshake: there is no back-pressure. A write is accepted on any clk
// where wr_en=1, busy=0, clear=0 and wr_addr<=783; otherwise it is dropped,
// never queued. busy rises the clk after clear is sampled and falls the clk
// the last cell (783) is zeroed, 784 clks in total.
module mnist_canvas_renderer #(
  parameter logic [9:0] X0           = 10'd208,
  parameter logic [9:0] Y0           = 10'd128,
  parameter int         SCALE_LOG2   = 3,
  parameter logic [7:0] BORDER_COLOR = 8'hE0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       wr_en,
  input  logic [9:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       clear,
  output logic       busy,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb
);

  import mnist_pkg::*;

  localparam int         SPAN  = IMG_DIM << SCALE_LOG2;   // canvas side in pixels
  localparam logic [9:0] X_END = X0 + 10'(SPAN);          // first column past interior
  localparam logic [9:0] Y_END = Y0 + 10'(SPAN);
  localparam logic [9:0] X_BL  = X0 - 10'd1;              // border column/row left/top
  localparam logic [9:0] Y_BT  = Y0 - 10'd1;

  // ---------------------------------------------------------------------------
  // Clear-sweep FSM and write arbitration
  // ---------------------------------------------------------------------------
  clr_state_t        clr_state;
  logic [ADDR_W-1:0] clr_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_state <= CLR_IDLE;
      clr_cnt   <= '0;
      busy      <= 1'b0;
    end else begin
      case (clr_state)
        CLR_IDLE: begin
          if (clear) begin
            clr_state <= CLR_SWEEP;
            clr_cnt   <= '0;
            busy      <= 1'b1;
          end
        end
        CLR_SWEEP: begin
          if (clear) begin
            clr_cnt <= '0;
          end else if (clr_cnt == LAST_ADDR) begin
            clr_state <= CLR_IDLE;
            clr_cnt   <= '0;
            busy      <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          clr_state <= CLR_IDLE;
          clr_cnt   <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [PIX_W-1:0]  ram_wdata;

  // Reset blocks the sweep write too, so a reset mid-sweep leaves the cell
  // under the counter untouched.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (!reset) begin
      if (clr_state == CLR_SWEEP) begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt;
        ram_wdata = '0;
      end else if (wr_en && !clear && (wr_addr <= LAST_ADDR)) begin
        ram_we = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: geometry and buffer address
  // ---------------------------------------------------------------------------
  logic [9:0]        dx;
  logic [9:0]        dy;
  logic [4:0]        col;
  logic [4:0]        row;
  logic [ADDR_W-1:0] row_w;
  logic [ADDR_W-1:0] rd_addr;
  logic              inside_c;
  logic              outer_c;

  always_comb begin
    dx       = x - X0;
    dy       = y - Y0;
    col      = 5'(dx >> SCALE_LOG2);
    row      = 5'(dy >> SCALE_LOG2);
    row_w    = {5'd0, row};
    // row*28 as 16+8+4 shifts.
    rd_addr  = (row_w << 4) + (row_w << 3) + (row_w << 2) + {5'd0, col};
    inside_c = (x >= X0) && (x < X_END) && (y >= Y0) && (y < Y_END);
    outer_c  = (x >= X_BL) && (x <= X_END) && (y >= Y_BT) && (y <= Y_END);
  end

  logic             inside_q;
  logic             border_q;
  logic             video_on_q;
  logic             hsync_q;
  logic             vsync_q;
  logic [PIX_W-1:0] pix;

  // The RAM's read register is the stage-1 register for the pixel value,
  // which is what keeps the whole path at 2 clk. Syncs idle high (inactive).
  always_ff @(posedge clk) begin
    if (reset) begin
      inside_q   <= 1'b0;
      border_q   <= 1'b0;
      video_on_q <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else begin
      inside_q   <= inside_c;
      border_q   <= outer_c && !inside_c;
      video_on_q <= video_on;
      hsync_q    <= hsync_in;
      vsync_q    <= vsync_in;
    end
  end

  mnist_img_ram u_img_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (pix)
  );

  // ---------------------------------------------------------------------------
  // Stage 2: colour select
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      hsync <= hsync_q;
      vsync <= vsync_q;
      if (!video_on_q) begin
        rgb <= '0;
      end else if (border_q) begin
        rgb <= BORDER_COLOR;
      end else if (inside_q) begin
        rgb <= gray_to_rgb332(pix);
      end else begin
        rgb <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mnist_canvas_renderer.sv
// tb_mnist_canvas_renderer
// Self-checking bench for mnist_canvas_renderer. Pixels are driven on the
// falling edge; each one pushes its expected {rgb, hsync, vsync} into a queue
// computed from a cell-array model of the image. A monitor pops and compares
// two clocks after each checked pixel was sampled.
module tb_mnist_canvas_renderer;

  localparam int CX0  = 208;
  localparam int CY0  = 128;
  localparam int CSZ  = 8;
  localparam int CDIM = 28;
  localparam int CEND_X = CX0 + CDIM * CSZ;  // 432
  localparam int CEND_Y = CY0 + CDIM * CSZ;  // 352

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       video_on = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic       wr_en = 1'b0;
  logic [9:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       clear = 1'b0;
  logic       busy;
  logic       hsync;
  logic       vsync;
  logic [7:0] rgb;

  always #5 clk = ~clk;

  mnist_canvas_renderer dut (
    .clk      (clk),
    .reset    (reset),
    .x        (x),
    .y        (y),
    .video_on (video_on),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clear    (clear),
    .busy     (busy),
    .hsync    (hsync),
    .vsync    (vsync),
    .rgb      (rgb)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q[$];
  logic [7:0] model [0:783];
  logic       chk_en = 1'b0;
  logic [1:0] chk_d = 2'b00;
  logic [9:0] mon_exp;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gray332(input logic [7:0] g);
    int r;
    int b;
    r = int'(g) / 32;
    b = int'(g) / 64;
    return 8'(r * 32 + r * 4 + b);
  endfunction

  function automatic logic [7:0] ref_rgb(input int px, input int py, input logic von);
    if (!von) return 8'h00;
    if (px >= CX0 && px < CEND_X && py >= CY0 && py < CEND_Y)
      return gray332(model[((py - CY0) / CSZ) * CDIM + (px - CX0) / CSZ]);
    if (px >= CX0 - 1 && px <= CEND_X && py >= CY0 - 1 && py <= CEND_Y)
      return 8'hE0;
    return 8'h00;
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) chk_d <= {chk_d[0], chk_en};

  always @(negedge clk) begin
    if (chk_d[1]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pix_queue actual=empty expected=entry at %0t", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pix{rgb,hs,vs}", {22'd0, rgb, hsync, vsync}, {22'd0, mon_exp});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_pix(input int px, input int py, input logic von,
                           input logic hs, input logic vs);
    x        = 10'(px);
    y        = 10'(py);
    video_on = von;
    hsync_in = hs;
    vsync_in = vs;
    chk_en   = 1'b1;
    exp_q.push_back({ref_rgb(px, py, von), hs, vs});
    @(negedge clk);
    chk_en   = 1'b0;
  endtask

  task automatic write_cell(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 10'(a);
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
    if (a < 784) model[a] = d;
  endtask

  task automatic fill_all(input logic [7:0] d);
    for (int c = 0; c < 784; c++) write_cell(c, d);
  endtask

  task automatic scan_cells();
    for (int c = 0; c < 784; c++)
      drive_pix(CX0 + (c % CDIM) * CSZ + int'($urandom_range(0, 7)),
                CY0 + (c / CDIM) * CSZ + int'($urandom_range(0, 7)), 1'b1, 1'b1, 1'b1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Counts clocks with busy high; issues one write to cell 5 at count drop_at.
  task automatic count_busy(input int drop_at, output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      wr_en   = (n == drop_at);
      wr_addr = 10'd5;
      wr_data = 8'h77;
      n++;
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int px;
    int py;

    // Reset with inputs at non-idle values so the reset state is visible.
    x = 10'd220; y = 10'd140; video_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rgb", {24'd0, rgb}, 32'h0);
    check("rst_hsync", {31'd0, hsync}, 32'h1);
    check("rst_vsync", {31'd0, vsync}, 32'h1);
    check("rst_busy", {31'd0, busy}, 32'h0);
    hsync_in = 1'b1; vsync_in = 1'b1; video_on = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Random image, then the specific cells used below.
    for (int c = 0; c < 784; c++) write_cell(c, 8'($urandom_range(0, 255)));
    write_cell(0, 8'hFF);
    write_cell(783, 8'h80);
    write_cell(30, 8'h40);   // row 1, col 2
    write_cell(31, 8'hB7);

    drive_pix(208, 128, 1'b1, 1'b1, 1'b1);   // FF
    drive_pix(431, 351, 1'b1, 1'b1, 1'b1);   // 92
    drive_pix(207, 200, 1'b1, 1'b1, 1'b1);   // border
    drive_pix(432, 127, 1'b1, 1'b1, 1'b1);   // border corner
    drive_pix(207, 127, 1'b1, 1'b1, 1'b1);
    drive_pix(432, 352, 1'b1, 1'b1, 1'b1);
    drive_pix(300, 352, 1'b1, 1'b1, 1'b1);
    drive_pix(433, 300, 1'b1, 1'b1, 1'b1);   // just outside border
    drive_pix(100, 100, 1'b1, 1'b1, 1'b1);
    drive_pix(300, 300, 1'b0, 1'b1, 1'b1);   // inside, blanked
    drive_pix(207, 200, 1'b0, 1'b1, 1'b1);   // border, blanked
    for (int xx = 224; xx <= 232; xx++) drive_pix(xx, 136, 1'b1, 1'b1, 1'b1);

    // Sync alignment.
    repeat (4)  drive_pix(300, 200, 1'b1, 1'b1, 1'b1);
    repeat (96) drive_pix(300, 200, 1'b1, 1'b0, 1'b1);
    repeat (4)  drive_pix(300, 200, 1'b1, 1'b1, 1'b1);
    repeat (96) drive_pix(10, 10, 1'b0, 1'b1, 1'b0);
    repeat (4)  drive_pix(10, 10, 1'b0, 1'b1, 1'b1);

    // Random pixels, biased toward the canvas and its edges.
    repeat (400) begin
      if ($urandom_range(0, 1) == 0) begin
        px = int'($urandom_range(200, 440));
        py = int'($urandom_range(120, 360));
      end else begin
        px = int'($urandom_range(0, 639));
        py = int'($urandom_range(0, 479));
      end
      drive_pix(px, py, ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    // Full clear with a dropped write mid-sweep.
    fill_all(8'hFF);
    pulse_clear();
    count_busy(300, n);
    check("clear_len", n, 784);
    for (int c = 0; c < 784; c++) model[c] = 8'h00;
    scan_cells();

    // Restart at cnt=400.
    fill_all(8'hFF);
    pulse_clear();
    repeat (400) @(negedge clk);
    check("busy_mid", {31'd0, busy}, 32'h1);
    pulse_clear();
    count_busy(-1, n);
    check("restart_len", n, 784);
    for (int c = 0; c < 784; c++) model[c] = 8'h00;
    scan_cells();

    // Reset at cnt=100.
    fill_all(8'hFF);
    pulse_clear();
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'h0);
    reset = 1'b0;
    for (int c = 0; c < 100; c++) model[c] = 8'h00;
    scan_cells();

    // Out-of-range write changes nothing.
    write_cell(800, 8'h33);
    scan_cells();

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
